// File: rtl/proc_pkg.sv
// proc_pkg: shared state encoding, opcodes and instruction field layout for proc_arbiter
package proc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic [1:0] F_LOAD = 2'b00;
  localparam logic [1:0] F_MOVE = 2'b01;
  localparam logic [1:0] F_ADD  = 2'b10;
  localparam logic [1:0] F_SUB  = 2'b11;

  localparam int F_W   = 2;
  localparam int RX_W  = 2;
  localparam int RY_W  = 2;
  localparam int HDR_W = F_W + RX_W + RY_W;

  // Op is {F, Rx, Ry, Data[n-1:0]}; offsets are relative to the data width n
  function automatic int op_w(input int n);
    return n + HDR_W;
  endfunction

  function automatic int ry_lsb(input int n);
    return n;
  endfunction

  function automatic int rx_lsb(input int n);
    return n + RY_W;
  endfunction

  function automatic int f_lsb(input int n);
    return n + RY_W + RX_W;
  endfunction

endpackage

// File: rtl/proc_arbiter_if.sv
// proc_arbiter_if: requester, processor and status signals of proc_arbiter
interface proc_arbiter_if #(
  parameter int N = 8
);
  import proc_pkg::*;

  logic                Req0, Req1;
  logic [op_w(N)-1:0]  Op0, Op1;
  logic                Gnt0, Gnt1;
  logic                Rsp0, Rsp1;
  logic [N-1:0]        Result;
  logic                Err;
  logic                w;
  logic [F_W-1:0]      F;
  logic [RX_W-1:0]     Rx;
  logic [RY_W-1:0]     Ry;
  logic [N-1:0]        Data;
  logic                Done;
  logic [N-1:0]        BusWires;
  logic                Busy;

  modport slave (
    input  Req0, Req1, Op0, Op1, Done, BusWires,
    output Gnt0, Gnt1, Rsp0, Rsp1, Result, Err, w, F, Rx, Ry, Data, Busy
  );

  modport master (
    output Req0, Req1, Op0, Op1, Done, BusWires,
    input  Gnt0, Gnt1, Rsp0, Rsp1, Result, Err, w, F, Rx, Ry, Data, Busy
  );

endinterface

// File: rtl/proc_rr_arb.sv
// proc_rr_arb: two-way round-robin arbiter, requester 0 favoured after reset
module proc_rr_arb (
  input  logic Clock,
  input  logic Reset,
  input  logic Req0,
  input  logic Req1,
  input  logic en,
  output logic gnt0,
  output logic gnt1
);

  logic prio1;

  assign gnt0 = en & Req0 & (~Req1 | ~prio1);
  assign gnt1 = en & Req1 & (~Req0 |  prio1);

  // After any grant, favour the other requester on the next contention
  always_ff @(posedge Clock or negedge Reset)
    if (!Reset) prio1 <= 1'b0;
    else if (gnt0 | gnt1) prio1 <= gnt0;

endmodule

// File: rtl/proc_arbiter.sv
// proc_arbiter: grants one of two requesters, issues its instruction and returns the completion
module proc_arbiter #(
  parameter int TIMEOUT = 7,
  parameter int N       = 8
) (
  input logic           Clock,
  input logic           Reset,
  proc_arbiter_if.slave bus
);
  import proc_pkg::*;

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int OW = op_w(N);
  localparam int FL = f_lsb(N);
  localparam int XL = rx_lsb(N);
  localparam int YL = ry_lsb(N);

  state_t          state;
  logic            owner;
  logic [CW-1:0]   cnt;
  logic            g0, g1;
  logic [OW-1:0]   op;

  assign op       = g1 ? bus.Op1 : bus.Op0;
  assign bus.Gnt0 = g0;
  assign bus.Gnt1 = g1;
  assign bus.Busy = state != IDLE;

  proc_rr_arb u_arb (
    .Clock(Clock),
    .Reset(Reset),
    .Req0 (bus.Req0),
    .Req1 (bus.Req1),
    .en   (Reset && state == IDLE),
    .gnt0 (g0),
    .gnt1 (g1)
  );

  // Sequencer: latch the granted Op, pulse w once, then wait for Done or give up after TIMEOUT
  always_ff @(posedge Clock or negedge Reset)
    if (!Reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      cnt        <= '0;
      bus.w      <= 1'b0;
      bus.Rsp0   <= 1'b0;
      bus.Rsp1   <= 1'b0;
      bus.Err    <= 1'b0;
      bus.Result <= '0;
      bus.F      <= '0;
      bus.Rx     <= '0;
      bus.Ry     <= '0;
      bus.Data   <= '0;
    end else begin
      bus.w    <= 1'b0;
      bus.Rsp0 <= 1'b0;
      bus.Rsp1 <= 1'b0;
      bus.Err  <= 1'b0;
      case (state)
        IDLE:
          if (g0 | g1) begin
            owner    <= g1;
            bus.F    <= op[FL +: F_W];
            bus.Rx   <= op[XL +: RX_W];
            bus.Ry   <= op[YL +: RY_W];
            bus.Data <= op[N-1:0];
            bus.w    <= 1'b1;
            state    <= ISSUE;
          end
        ISSUE: begin
          cnt   <= CW'(1);
          state <= WAIT;
        end
        WAIT:
          if (bus.Done || cnt == CW'(TIMEOUT)) begin
            bus.Rsp0 <= ~owner;
            bus.Rsp1 <= owner;
            bus.Err  <= ~bus.Done;
            if (bus.Done) bus.Result <= bus.BusWires;
            cnt      <= '0;
            state    <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        default: state <= IDLE;
      endcase
    end

  a_gnt_onehot: assert property (@(posedge Clock) disable iff (!Reset) !(bus.Gnt0 && bus.Gnt1));
  a_rsp_onehot: assert property (@(posedge Clock) disable iff (!Reset) !(bus.Rsp0 && bus.Rsp1));
  a_w_idle:     assert property (@(posedge Clock) disable iff (!Reset) state == IDLE |-> !bus.w);

endmodule

// File: tb/tb_proc_arbiter.sv
// tb_proc_arbiter: directed scenarios with a cycle-level reference model and a processor responder
module tb_proc_arbiter;
  import proc_pkg::*;

  localparam int N  = 8;
  localparam int TO = 7;

  logic Clock = 1'b0;
  logic Reset = 1'b0;
  int   cyc = 0, errors = 0, checks = 0;

  proc_arbiter_if #(.N(N)) bus ();

  proc_arbiter #(.TIMEOUT(TO), .N(N)) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus  (bus)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, errors=%0d", errors);
    $fatal(1);
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [13:0] mk(input logic [1:0] f, input logic [1:0] x,
                                     input logic [1:0] y, input logic [7:0] d);
    return {f, x, y, d};
  endfunction

  // Processor stand-in: load/move answer one cycle after w, add/sub three cycles after w
  logic [N-1:0] r [4];
  logic [N-1:0] res;
  logic         proc_on = 1'b1;
  int           cd = 0;
  initial begin
    for (int i = 0; i < 4; i++) r[i] = '0;
    bus.Done = 1'b0;
    bus.BusWires = '0;
    forever begin
      @(posedge Clock);
      #1;
      bus.Done = 1'b0;
      if (!Reset) cd = 0;
      else begin
        if (cd > 0) begin
          cd--;
          if (cd == 0) begin
            bus.Done = 1'b1;
            bus.BusWires = res;
          end
        end
        if (bus.w && proc_on) begin
          case (bus.F)
            F_LOAD:  res = bus.Data;
            F_MOVE:  res = r[bus.Ry];
            F_ADD:   res = r[bus.Rx] + r[bus.Ry];
            default: res = r[bus.Rx] - r[bus.Ry];
          endcase
          r[bus.Rx] = res;
          cd = bus.F[1] ? 3 : 1;
        end
      end
    end
  end

  // Reference model: age counts cycles since the grant (1 = issue cycle, k+1 = k-th wait cycle)
  logic        busy = 0, own = 0, pref1 = 0, rsp_now = 0, rsp_err = 0, eg0, eg1;
  int          age = 0;
  logic [13:0] m_op = '0;
  logic [7:0]  m_res = '0;
  initial forever begin
    @(negedge Clock);
    if (!Reset) begin
      busy = 0; age = 0; own = 0; pref1 = 0; rsp_now = 0; rsp_err = 0; m_op = '0; m_res = '0;
    end
    eg0 = Reset && !busy && bus.Req0 && (!bus.Req1 || !pref1);
    eg1 = Reset && !busy && bus.Req1 && (!bus.Req0 || pref1);
    chk("gnt0", bus.Gnt0, eg0);
    chk("gnt1", bus.Gnt1, eg1);
    chk("rsp0", bus.Rsp0, rsp_now && !own);
    chk("rsp1", bus.Rsp1, rsp_now && own);
    chk("err", bus.Err, rsp_now && rsp_err);
    chk("w", bus.w, busy && age == 1);
    chk("busy", bus.Busy, busy);
    chk("result", bus.Result, m_res);
    chk("f", bus.F, m_op[13:12]);
    chk("rx", bus.Rx, m_op[11:10]);
    chk("ry", bus.Ry, m_op[9:8]);
    chk("data", bus.Data, m_op[7:0]);
    if (Reset) begin
      rsp_now = 0;
      rsp_err = 0;
      if (busy) begin
        if (age == 1) age = 2;
        else if (bus.Done) begin
          rsp_now = 1; m_res = bus.BusWires; busy = 0;
        end else if (age - 1 == TO) begin
          rsp_now = 1; rsp_err = 1; busy = 0;
        end else age++;
      end else if (eg0 || eg1) begin
        busy = 1; age = 1; own = eg1; pref1 = eg0;
        m_op = eg1 ? bus.Op1 : bus.Op0;
      end
    end
  end

  task automatic issue(input int who, input logic [13:0] op, output int gc);
    logic ok = 0;
    @(posedge Clock);
    #1;
    if (who == 0) begin bus.Op0 = op; bus.Req0 = 1; end
    else begin bus.Op1 = op; bus.Req1 = 1; end
    gc = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clock);
      #1;
      if (who == 0 ? bus.Gnt0 : bus.Gnt1) begin ok = 1; gc = cyc; break; end
    end
    chk("gnt_seen", ok, 1);
    @(posedge Clock);
    #1;
    bus.Req0 = 0;
    bus.Req1 = 0;
    chk("w_after_gnt", bus.w, 1);
  endtask

  task automatic wait_rsp(output int rc, output int who, output int err, output int rv);
    logic ok = 0;
    rc = -1; who = -1; err = -1; rv = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clock);
      #1;
      if (bus.Rsp0 || bus.Rsp1) begin
        ok = 1; rc = cyc; who = bus.Rsp1; err = bus.Err; rv = bus.Result;
        break;
      end
    end
    chk("rsp_seen", ok, 1);
  endtask

  int gc, rc, who, err, rv, ng, nr;
  initial begin
    bus.Req0 = 0; bus.Req1 = 0; bus.Op0 = '0; bus.Op1 = '0;
    repeat (3) @(posedge Clock);
    #1;
    chk("rst_busy", bus.Busy, 0);
    chk("rst_result", bus.Result, 0);
    Reset = 1;

    issue(0, mk(F_LOAD, 1, 0, 8'h5A), gc);
    wait_rsp(rc, who, err, rv);
    chk("load_latency", rc - gc, 3);
    chk("load_owner", who, 0);
    chk("load_err", err, 0);
    chk("load_result", rv, 'h5A);

    issue(1, mk(F_LOAD, 0, 0, 8'd3), gc);
    wait_rsp(rc, who, err, rv);
    issue(0, mk(F_LOAD, 1, 0, 8'd4), gc);
    wait_rsp(rc, who, err, rv);
    issue(1, mk(F_ADD, 0, 1, 8'h00), gc);
    wait_rsp(rc, who, err, rv);
    chk("add_latency", rc - gc, 5);
    chk("add_owner", who, 1);
    chk("add_result", rv, 'h07);

    @(posedge Clock);
    #1;
    bus.Op0 = mk(F_LOAD, 2, 0, 8'h11);
    bus.Op1 = mk(F_LOAD, 3, 0, 8'h22);
    bus.Req0 = 1; bus.Req1 = 1;
    ng = 0; nr = 0;
    for (int i = 0; i < 80 && nr < 4; i++) begin
      @(negedge Clock);
      #1;
      if (bus.Gnt0 || bus.Gnt1) begin chk($sformatf("rr_gnt%0d", ng), bus.Gnt1, ng % 2); ng++; end
      if (bus.Rsp0 || bus.Rsp1) begin
        chk($sformatf("rr_owner%0d", nr), bus.Rsp1, nr % 2);
        chk($sformatf("rr_result%0d", nr), bus.Result, (nr % 2) ? 'h22 : 'h11);
        nr++;
      end
      @(posedge Clock);
      #1;
      if (ng == 4) begin bus.Req0 = 0; bus.Req1 = 0; end
    end
    chk("rr_rsp_count", nr, 4);

    proc_on = 0;
    issue(0, mk(F_LOAD, 2, 0, 8'h99), gc);
    wait_rsp(rc, who, err, rv);
    proc_on = 1;
    chk("to_latency", rc - gc, 9);
    chk("to_err", err, 1);
    chk("to_owner", who, 0);
    chk("to_result_kept", rv, 'h22);
    issue(1, mk(F_MOVE, 0, 2, 8'h00), gc);
    wait_rsp(rc, who, err, rv);
    chk("move_latency", rc - gc, 3);
    chk("move_err", err, 0);
    chk("move_result", rv, 'h11);

    issue(1, mk(F_LOAD, 0, 0, 8'h44), gc);
    @(posedge Clock);
    @(posedge Clock);
    #1;
    bus.Op0 = mk(F_LOAD, 1, 0, 8'h55);
    bus.Req0 = 1;
    @(negedge Clock);
    #1;
    chk("rspcyc_offset", cyc - gc, 3);
    chk("rspcyc_rsp1", bus.Rsp1, 1);
    chk("rspcyc_gnt0", bus.Gnt0, 1);
    chk("rspcyc_result", bus.Result, 'h44);
    @(posedge Clock);
    #1;
    bus.Req0 = 0;
    wait_rsp(rc, who, err, rv);
    chk("rspcyc_owner", who, 0);
    chk("rspcyc_result2", rv, 'h55);

    issue(0, mk(F_SUB, 1, 2, 8'h0F), gc);
    @(posedge Clock);
    #3;
    Reset = 0;
    #1;
    chk("arst_w", bus.w, 0);
    chk("arst_busy", bus.Busy, 0);
    chk("arst_result", bus.Result, 0);
    chk("arst_f", bus.F, 0);
    chk("arst_rx", bus.Rx, 0);
    chk("arst_ry", bus.Ry, 0);
    chk("arst_data", bus.Data, 0);
    chk("arst_rsp", bus.Rsp0 | bus.Rsp1, 0);
    chk("arst_err", bus.Err, 0);
    repeat (2) @(posedge Clock);
    #1;
    Reset = 1;
    bus.Op0 = mk(F_LOAD, 2, 0, 8'h66);
    bus.Op1 = mk(F_LOAD, 3, 0, 8'h77);
    bus.Req0 = 1; bus.Req1 = 1;
    @(negedge Clock);
    #1;
    chk("prio_rst_gnt0", bus.Gnt0, 1);
    chk("prio_rst_gnt1", bus.Gnt1, 0);
    @(posedge Clock);
    #1;
    bus.Req0 = 0; bus.Req1 = 0;
    wait_rsp(rc, who, err, rv);
    chk("prio_rst_result", rv, 'h66);
    issue(1, mk(F_LOAD, 3, 0, 8'h77), gc);
    wait_rsp(rc, who, err, rv);
    chk("post_rst_owner", who, 1);
    chk("post_rst_latency", rc - gc, 3);
    chk("post_rst_result", rv, 'h77);

    repeat (2) @(posedge Clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/proc_arbiter.md
PROC_ARBITER -- requirements
Module: proc_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 7: maximum WAIT-state cycles before an instruction is abandoned.
REQ-002 SHALL have parameter N, default 8: data and bus width.
REQ-003 SHALL have port Clock  in  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports Req0, Req1  in  1 each  requester instruction request, held high until granted.
REQ-006 SHALL have ports Op0, Op1  in  6+N each  requester instruction {F[1:0], Rx[1:0], Ry[1:0], Data[N-1:0]}.
REQ-007 SHALL have ports Gnt0, Gnt1  out  1 each  one-cycle pulse; the Op of the granted requester is accepted.
REQ-008 SHALL have ports Rsp0, Rsp1  out  1 each  one-cycle completion pulse to the owning requester.
REQ-009 SHALL have port Result  out  N  bus value captured at completion; valid while Rsp0 or Rsp1 is high.
REQ-010 SHALL have port Err  out  1  high with Rsp0 or Rsp1 when the instruction timed out.
REQ-011 SHALL have ports w, F, Rx, Ry, Data  out  1, 2, 2, 2, N  processor instruction drive.
REQ-012 SHALL have ports Done  in  1  and BusWires  in  N  processor completion and bus.
REQ-013 SHALL have port Busy  out  1  high in every state except IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, ISSUE, WAIT.
REQ-015 IDLE: SHALL sample Req0 and Req1 only in this state; if any is high, SHALL assert exactly one Gnt, latch that requester's Op and identity, and go to ISSUE.
REQ-016 IDLE: with no request, SHALL remain in IDLE.
REQ-017 Arbitration SHALL be round-robin: when both requests are high, grant the requester not granted last; a single request is granted immediately.
REQ-018 After reset, requester 0 SHALL have priority.
REQ-019 ISSUE: SHALL drive w=1 for exactly one cycle, with F, Rx, Ry and Data taken from the latched Op, then go to WAIT.
REQ-020 WAIT: SHALL drive w=0 and hold F, Rx, Ry and Data stable until the state is left.
REQ-021 WAIT: SHALL count cycles starting from 1; a Done while in WAIT SHALL register BusWires into Result, pulse the owner's Rsp in the next cycle with Err=0, and return to IDLE.
REQ-022 WAIT: when the count reaches TIMEOUT with no Done, SHALL pulse the owner's Rsp with Err=1, leave Result unchanged, and return to IDLE.
REQ-023 Done observed outside WAIT SHALL be ignored.
REQ-024 The Rsp cycle is an IDLE cycle; a new grant MAY occur in that same cycle.
REQ-025 Latency SHALL be: Gnt in cycle N, w in cycle N+1, Rsp one cycle after Done (load/move: Done in N+2, Rsp in N+3; add/sub: Done in N+4, Rsp in N+5).
REQ-026 Gnt0 and Gnt1 SHALL never be high together; Rsp0 and Rsp1 SHALL never be high together.
REQ-027 Outside WAIT and ISSUE, w SHALL be 0; outside the Rsp cycle, Err SHALL be 0.

Reset
REQ-028 Reset low SHALL immediately force state IDLE, w=0, Gnt=0, Rsp=0, Err=0, Busy=0, Result=0, F=Rx=Ry=0, Data=0, timeout count=0, and priority to requester 0.
REQ-029 Reset asserted mid-instruction SHALL abandon that instruction with no Rsp issued.

Structure
REQ-030 Shared package proc_pkg SHALL hold the FSM state encoding, the F opcode constants (00 load, 01 move, 10 add, 11 sub), and the Op field widths and offsets.
REQ-031 The two-way round-robin arbiter SHALL be a sub-module, proc_rr_arb, with inputs Req0, Req1 and an update enable, and grant outputs.

Verification
REQ-032 Scenario: Req0 with load R1, Data=8'h5A -> Gnt0 in cycle N, w=1 in N+1, Rsp0 in N+3, Result=8'h5A, Err=0.
REQ-033 Scenario: Req1 with add R0,R1, where R0=3 and R1=4 -> Rsp1 five cycles after Gnt1, Result=8'h07.
REQ-034 Scenario: Req0 and Req1 held high together for 4 instructions -> grants alternate 0,1,0,1 and each Rsp goes to the correct owner.
REQ-035 Scenario: Done tied low -> Rsp pulse with Err=1 after TIMEOUT=7 WAIT cycles, Result unchanged, next request granted.
REQ-036 Scenario: Reset pulsed low during WAIT -> all outputs 0 immediately and no Rsp; after release, Req1 alone is granted.
REQ-037 Scenario: Req0 rises in the Rsp cycle of a previous instruction -> Gnt0 in that same cycle.
